// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, frame
// constants and the baud divider helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: free-running modulo-CLKS_PER_BIT counter with a
// synchronous clear and a one-cycle tick on terminal count.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clr || cnt == TERM) cnt <= '0;
    else                         cnt <= cnt + 1'b1;
  end

  assign bit_tick = (cnt == TERM);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. TX and READY come straight from flops.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);

  state_t     state;
  logic [7:0] shreg;
  logic [3:0] bitcnt;
  logic       stopcnt;
  logic       par;
  logic       bit_tick;

  // Counter is held in reset while idle, so the accept edge starts a fresh period.
  uart_baud_gen #(.CLKS_PER_BIT(CPB)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state == IDLE),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bitcnt  <= '0;
      stopcnt <= 1'b0;
      par     <= 1'b0;
      tx      <= 1'b1;
      ready   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx    <= 1'b1;
          ready <= 1'b1;
          if (send) begin
            shreg  <= data;
            bitcnt <= '0;
            par    <= (PARITY_ODD != 0);
            state  <= START;
            tx     <= 1'b0;
            ready  <= 1'b0;
          end
        end
        START: if (bit_tick) begin
          state <= DATA;
          tx    <= shreg[0];
        end
        DATA: if (bit_tick) begin
          par    <= par ^ shreg[0];
          shreg  <= {1'b0, shreg[7:1]};
          bitcnt <= bitcnt + 4'd1;
          if (bitcnt == 4'(DATA_BITS - 1)) begin
            stopcnt <= 1'b0;
            if (PARITY_EN != 0) begin
              state <= PARITY;
              tx    <= par ^ shreg[0];
            end else begin
              state <= STOP;
              tx    <= 1'b1;
            end
          end else begin
            tx <= shreg[1];
          end
        end
        PARITY: if (bit_tick) begin
          state   <= STOP;
          stopcnt <= 1'b0;
          tx      <= 1'b1;
        end
        STOP: if (bit_tick) begin
          if (stopcnt == (STOP_BITS == 2)) begin
            state <= IDLE;
            ready <= 1'b1;
          end else begin
            stopcnt <= 1'b1;
          end
          tx <= 1'b1;
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed + random frames on three UART configurations, each cycle
// compared against a bit-list model of the expected line waveform.
module tb_uart_tx_core;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] send;
  logic [7:0] data [3];
  wire  [2:0] ready;
  wire  [2:0] tx;

  int total = 0;
  int bad   = 0;

  // per-instance configuration: 0 = 10 clk/bit plain, 1 = defaults, 2 = parity + 2 stops
  int cpb   [3] = '{10, 868, 10};
  int paren [3] = '{0, 0, 1};
  int podd  [3] = '{0, 0, 0};
  int nstop [3] = '{1, 1, 2};

  always #5 clk = ~clk;

  uart_tx_core #(.CLK_FREQ(100_000_000), .BAUD(10_000_000)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .send(send[0]), .data(data[0]), .ready(ready[0]), .tx(tx[0]));
  uart_tx_core u1 (
    .clk(clk), .rst_n(rst_n[1]), .send(send[1]), .data(data[1]), .ready(ready[1]), .tx(tx[1]));
  uart_tx_core #(.CLK_FREQ(100_000_000), .BAUD(10_000_000), .PARITY_EN(1), .PARITY_ODD(0),
                 .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .send(send[2]), .data(data[2]), .ready(ready[2]), .tx(tx[2]));

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic chk_idle(input int u, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_tx", tx[u], 1'b1);
      chk("idle_ready", ready[u], 1'b1);
    end
  endtask

  // Called at a negedge. Accepts d at the next posedge (edge 0) and checks
  // every cycle through edge L, where READY must be back high.
  task automatic run_frame(input int u, input logic [7:0] d, input bit hold,
                           input int busy_at, input int abort_at);
    logic exp_bits[$];
    int   c, l;
    c = cpb[u];
    exp_bits = {};
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    if (paren[u] != 0) exp_bits.push_back((^d) ^ (podd[u] != 0));
    for (int i = 0; i < nstop[u]; i++) exp_bits.push_back(1'b1);
    l = exp_bits.size() * c;

    chk("pre_ready", ready[u], 1'b1);
    data[u] = d;
    send[u] = 1'b1;
    @(posedge clk);
    for (int e = 0; e <= l; e++) begin
      @(negedge clk);
      if (e == l) begin
        chk("end_ready", ready[u], 1'b1);
        chk("end_tx", tx[u], 1'b1);
      end else begin
        chk("frame_tx", tx[u], exp_bits[e / c]);
        chk("busy_ready", ready[u], 1'b0);
      end
      if (e == 0 && !hold) begin
        send[u] = 1'b0;
        data[u] = 8'($urandom);
      end
      if (e == busy_at) begin
        send[u] = 1'b1;
        data[u] = 8'h3C;
      end
      if (e == busy_at + 1) send[u] = 1'b0;
      if (e == abort_at) begin
        rst_n[u] = 1'b0;
        #1;
        chk("abort_tx", tx[u], 1'b1);
        chk("abort_ready", ready[u], 1'b1);
        @(negedge clk);
        chk("abort_hold_tx", tx[u], 1'b1);
        rst_n[u] = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    rst_n = 3'b000;
    send  = 3'b000;
    for (int i = 0; i < 3; i++) data[i] = 8'h00;

    repeat (10) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("rst_tx", tx[u], 1'b1);
      chk("rst_ready", ready[u], 1'b1);
    end
    rst_n = 3'b111;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
        chk("post_rst_tx", tx[u], 1'b1);
        chk("post_rst_ready", ready[u], 1'b1);
      end
    end

    // single byte, fast and default baud
    run_frame(0, 8'h08, 1'b0, -1, -1);
    run_frame(1, 8'h08, 1'b0, -1, -1);

    // SEND mid-frame must be ignored, and must not queue a second frame
    chk_idle(0, 3);
    run_frame(0, 8'hA5, 1'b0, 35, -1);
    chk_idle(0, 30);

    // back-to-back with SEND held high: one idle cycle between frames
    run_frame(0, 8'h55, 1'b1, -1, -1);
    run_frame(0, 8'hFF, 1'b1, -1, -1);
    send[0] = 1'b0;
    chk_idle(0, 20);

    // parity (even) and two stop bits
    run_frame(2, 8'h07, 1'b0, -1, -1);
    chk_idle(2, 5);

    // reset during data bit 3, then a clean frame
    run_frame(0, 8'hC3, 1'b0, -1, 45);
    chk_idle(0, 3);
    run_frame(0, 8'h96, 1'b0, -1, -1);

    // random bytes on the fast instances, one on the default-rate instance
    for (int k = 0; k < 12; k++) begin
      run_frame((k % 2 == 0) ? 0 : 2, 8'($urandom), 1'b0, -1, -1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    run_frame(1, 8'($urandom), 1'b0, -1, -1);
    chk_idle(1, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
